// File: rtl/requant_stage.sv
// requant_stage: per-channel requantization after the adder tree.
//   bias add -> Q31 multiply -> rounding right shift -> clamp.
//   Fixed 4-cycle latency, one beat per cycle, no backpressure.
// Build option: define REQUANT_RELU6_EN to clamp to [0, act_max] (unsigned
// output); otherwise the clamp is the full signed OUT_W range and act_max
// is ignored.
module requant_stage #(
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 8,
  parameter int NUM_CH  = 32,
  parameter int MULT_W  = 32,
  parameter int SHIFT_W = 5,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_addr,
  input  logic signed [ACC_W-1:0]   cfg_bias,
  input  logic signed [MULT_W-1:0]  cfg_mult,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic [OUT_W-1:0]          act_max,
  input  logic                      frame_start,
  input  logic                      valid_in,
  input  logic signed [ACC_W-1:0]   sum_in,
  output logic                      valid_out,
  output logic [CH_W-1:0]           ch_out,
  output logic [OUT_W-1:0]          q_out,
  output logic                      sat_seen
);

  localparam int STAGES = 4;
  localparam int A_W    = ACC_W + 1;       // biased sum
  localparam int P_W    = A_W + MULT_W;    // full product
  localparam int R_W    = P_W + 1;         // product plus rounding headroom

  // per-channel tables
  logic signed [ACC_W-1:0]  bias_tab  [NUM_CH];
  logic signed [MULT_W-1:0] mult_tab  [NUM_CH];
  logic [SHIFT_W-1:0]       shift_tab [NUM_CH];

  logic [CH_W-1:0]          ch_cnt, beat_ch;
  logic [STAGES:1]          vld_pipe;
  logic [STAGES-1:1]        fs_pipe;

  logic signed [A_W-1:0]    s1_a;
  logic signed [MULT_W-1:0] s1_mult;
  logic [SHIFT_W-1:0]       s1_shift;
  logic [CH_W-1:0]          s1_ch;

  logic signed [P_W-1:0]    s2_p;
  logic [SHIFT_W-1:0]       s2_shift;
  logic [CH_W-1:0]          s2_ch;

  logic signed [R_W-1:0]    s3_r;
  logic [CH_W-1:0]          s3_ch;

  logic signed [R_W-1:0]    p_ext, rnd, rsum, rnd_r;
  logic signed [R_W-1:0]    hi_b, lo_b;
  logic [OUT_W-1:0]         q_nxt;
  logic                     hit;

  assign valid_out = vld_pipe[STAGES];

  // channel of the incoming beat: frame_start on a valid beat forces channel 0
  always_comb begin
    beat_ch = frame_start ? '0 : ch_cnt;
  end

  // channel counter advances once per valid beat, wrapping at NUM_CH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ch_cnt <= '0;
    else if (valid_in)
      ch_cnt <= (beat_ch == CH_W'(NUM_CH - 1)) ? '0 : beat_ch + 1'b1;
  end

  // table writes; stage 1 reads the pre-write contents in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bias_tab[i]  <= '0;
        mult_tab[i]  <= '0;
        shift_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      bias_tab[cfg_addr]  <= cfg_bias;
      mult_tab[cfg_addr]  <= cfg_mult;
      shift_tab[cfg_addr] <= cfg_shift;
    end
  end

  // stages 1-3: bias add, multiply, rounded shift; valids travel alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      fs_pipe  <= '0;
      s1_a     <= '0;
      s1_mult  <= '0;
      s1_shift <= '0;
      s1_ch    <= '0;
      s2_p     <= '0;
      s2_shift <= '0;
      s2_ch    <= '0;
      s3_r     <= '0;
      s3_ch    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
      fs_pipe  <= {fs_pipe[STAGES-2:1], frame_start & valid_in};
      s1_a     <= {sum_in[ACC_W-1], sum_in} + {bias_tab[beat_ch][ACC_W-1], bias_tab[beat_ch]};
      s1_mult  <= mult_tab[beat_ch];
      s1_shift <= shift_tab[beat_ch];
      s1_ch    <= beat_ch;
      s2_p     <= P_W'(s1_a) * P_W'(s1_mult);
      s2_shift <= s1_shift;
      s2_ch    <= s1_ch;
      s3_r     <= rnd_r;
      s3_ch    <= s2_ch;
    end
  end

  // round half up: add 2^(30+shift), then arithmetic shift by 31+shift
  always_comb begin
    p_ext = {s2_p[P_W-1], s2_p};
    rnd   = {{(R_W-1){1'b0}}, 1'b1} << (8'd30 + 8'(s2_shift));
    rsum  = p_ext + rnd;
    rnd_r = rsum >>> (8'd31 + 8'(s2_shift));
  end

`ifdef REQUANT_RELU6_EN
  // ReLU6-style bounds: [0, act_max]
  always_comb begin
    lo_b = '0;
    hi_b = $signed({{(R_W-OUT_W){1'b0}}, act_max});
  end
`else
  logic unused_act;
  assign unused_act = ^act_max;

  // linear bounds: full signed OUT_W range
  always_comb begin
    lo_b = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    hi_b = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  end
`endif

  // clamp; hit flags a value that had to be pulled back to a bound
  always_comb begin
    q_nxt = s3_r[OUT_W-1:0];
    hit   = 1'b0;
    if (s3_r > hi_b) begin
      q_nxt = hi_b[OUT_W-1:0];
      hit   = 1'b1;
    end else if (s3_r < lo_b) begin
      q_nxt = lo_b[OUT_W-1:0];
      hit   = 1'b1;
    end
  end

  // stage 4 outputs hold between beats; a frame-start beat restarts the
  // sticky flag but its own clamp still sets it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out    <= '0;
      ch_out   <= '0;
      sat_seen <= 1'b0;
    end else if (vld_pipe[STAGES-1]) begin
      q_out    <= q_nxt;
      ch_out   <= s3_ch;
      sat_seen <= hit | (sat_seen & ~fs_pipe[STAGES-1]);
    end
  end

endmodule

// File: tb/tb_requant_stage.sv
// tb_requant_stage: directed plus randomized checks of requant_stage against
// a wide-integer arithmetic reference model (NUM_CH reduced to 4).
module tb_requant_stage;
  localparam int ACC_W = 48, OUT_W = 8, NUM_CH = 4, MULT_W = 32, SHIFT_W = 5;
  localparam int CH_W = 2;

`ifdef REQUANT_RELU6_EN
  localparam logic [7:0] EXP_NEG21 = 8'h00;
  localparam bit         SAT_NEG21 = 1'b1;
  localparam logic [7:0] EXP_1000  = 8'd96;
`else
  localparam logic [7:0] EXP_NEG21 = 8'hF6;
  localparam bit         SAT_NEG21 = 1'b0;
  localparam logic [7:0] EXP_1000  = 8'd127;
`endif

  logic clk, rst, cfg_we, frame_start, valid_in;
  logic [CH_W-1:0] cfg_addr;
  logic signed [ACC_W-1:0] cfg_bias, sum_in;
  logic signed [MULT_W-1:0] cfg_mult;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [OUT_W-1:0] act_max, q_out;
  logic valid_out, sat_seen;
  logic [CH_W-1:0] ch_out;

  requant_stage #(.ACC_W(ACC_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH),
                  .MULT_W(MULT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .act_max(act_max), .frame_start(frame_start), .valid_in(valid_in),
    .sum_in(sum_in), .valid_out(valid_out), .ch_out(ch_out),
    .q_out(q_out), .sat_seen(sat_seen));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  typedef struct packed {
    logic vld; logic fs; logic [CH_W-1:0] ch; logic [7:0] q; logic hit;
  } ent_t;
  ent_t pipe [4];
  logic signed [ACC_W-1:0]  m_bias [NUM_CH];
  logic signed [MULT_W-1:0] m_mult [NUM_CH];
  logic [SHIFT_W-1:0]       m_shift[NUM_CH];
  int m_cnt;
  logic m_vld, m_sat;
  logic [CH_W-1:0] m_ch;
  logic [7:0] m_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_bias[i] = '0; m_mult[i] = '0; m_shift[i] = '0;
    end
    m_cnt = 0; m_vld = 0; m_sat = 0; m_ch = '0; m_q = '0;
  endtask

  // requantize with unbounded integer arithmetic, then clamp
  task automatic compute(input logic signed [ACC_W-1:0] sum, input logic signed [ACC_W-1:0] b,
                         input logic signed [MULT_W-1:0] m, input logic [SHIFT_W-1:0] s,
                         output logic [7:0] q, output logic hit);
    logic signed [127:0] a, p, r, lo, hi;
    a = sum;
    a = a + b;
    p = a * m;
    r = (p + (128'sd1 <<< (30 + s))) >>> (31 + s);
`ifdef REQUANT_RELU6_EN
    lo = 0;
    hi = 0; hi[7:0] = act_max;
`else
    lo = -128;
    hi = 127;
`endif
    hit = 1'b0;
    if (r > hi) begin q = hi[7:0]; hit = 1'b1; end
    else if (r < lo) begin q = lo[7:0]; hit = 1'b1; end
    else q = r[7:0];
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_vld"}, 64'(valid_out), 64'(m_vld));
    chk({tag, "_ch"},  64'(ch_out),    64'(m_ch));
    chk({tag, "_q"},   64'(q_out),     64'(m_q));
    chk({tag, "_sat"}, 64'(sat_seen),  64'(m_sat));
  endtask

  // one clock: drive, advance DUT and model, compare everything
  task automatic step(input bit v, input bit fs, input logic signed [ACC_W-1:0] sum,
                      input bit we = 0, input logic [CH_W-1:0] addr = '0,
                      input logic signed [ACC_W-1:0] b = '0,
                      input logic signed [MULT_W-1:0] m = '0,
                      input logic [SHIFT_W-1:0] s = '0);
    ent_t e;
    valid_in = v; frame_start = fs; sum_in = sum;
    cfg_we = we; cfg_addr = addr; cfg_bias = b; cfg_mult = m; cfg_shift = s;
    e = '0;
    if (v) begin
      e.vld = 1'b1;
      e.fs  = fs;
      e.ch  = fs ? '0 : CH_W'(m_cnt);
      m_cnt = (int'(e.ch) + 1) % NUM_CH;
      compute(sum, m_bias[e.ch], m_mult[e.ch], m_shift[e.ch], e.q, e.hit);
    end
    @(posedge clk); #1;
    if (rst) begin
      model_reset();
    end else begin
      if (we) begin m_bias[addr] = b; m_mult[addr] = m; m_shift[addr] = s; end
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
      m_vld = pipe[3].vld;
      if (pipe[3].vld) begin
        m_ch  = pipe[3].ch;
        m_q   = pipe[3].q;
        m_sat = pipe[3].fs ? pipe[3].hit : (m_sat | pipe[3].hit);
      end
    end
    check_model("mdl");
  endtask

  task automatic beat_then_wait(input bit fs, input logic signed [ACC_W-1:0] sum);
    step(1, fs, sum);
    repeat (3) step(0, 0, '0);
  endtask

  task automatic expect_now(input string tag, input int ch, input logic [7:0] q, input bit sat);
    chk({tag, "_vld"}, 64'(valid_out), 64'd1);
    chk({tag, "_ch"},  64'(ch_out),    64'(ch));
    chk({tag, "_q"},   64'(q_out),     64'(q));
    chk({tag, "_sat"}, 64'(sat_seen),  64'(sat));
  endtask

  int seq_a [6] = '{0, 1, 2, 3, 0, 1};
  int seq_b [6] = '{0, 1, 0, 1, 2, 3};

  initial begin
    logic [63:0] rw;
    logic signed [ACC_W-1:0] rs, rb;
    logic signed [MULT_W-1:0] rm;
    rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    act_max = 8'd96; frame_start = 0; valid_in = 0; sum_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(valid_out), 64'd0);
    chk("rst_q",   64'(q_out),     64'd0);
    chk("rst_ch",  64'(ch_out),    64'd0);
    chk("rst_sat", 64'(sat_seen),  64'd0);
    rst = 1'b0;

    // basic scaling and rounding on channel 0
    step(0, 0, '0, 1, 2'd0, '0, 32'sh40000000, 5'd0);
    beat_then_wait(1, 48'sd20);   expect_now("p20", 0, 8'd10, 0);
    beat_then_wait(1, 48'sd21);   expect_now("p21", 0, 8'd11, 0);
    beat_then_wait(1, -48'sd21);  expect_now("n21", 0, EXP_NEG21, SAT_NEG21);

    step(0, 0, '0, 1, 2'd0, -48'sd100, 32'sh7FFFFFFF, 5'd2);
    beat_then_wait(1, 48'sd300);  expect_now("b300", 0, 8'd50, 0);

    // clamp and sticky flag
    step(0, 0, '0, 1, 2'd0, '0, 32'sh40000000, 5'd0);
    beat_then_wait(1, 48'sd1000); expect_now("c1000", 0, EXP_1000, 1);
    beat_then_wait(0, 48'sd5);    expect_now("sticky", 1, 8'd0, 1);
    beat_then_wait(1, 48'sd20);   expect_now("clear", 0, 8'd10, 0);

    // table write colliding with a read of the same channel
    step(0, 0, '0, 1, 2'd1, '0, 32'sh40000000, 5'd0);
    beat_then_wait(1, '0);
    step(1, 0, 48'sd100, 1, 2'd1, '0, 32'sh20000000, 5'd0);
    repeat (3) step(0, 0, '0);
    expect_now("old_mult", 1, 8'd50, 0);
    beat_then_wait(1, '0);
    beat_then_wait(0, 48'sd100);  expect_now("new_mult", 1, 8'd25, 0);

    // back-to-back channel numbering, with and without a mid-run frame_start
    for (int i = 0; i < 9; i++) begin
      if (i < 6) step(1, i == 0, 48'(i)); else step(0, 0, '0);
      if (i >= 3) begin
        chk("seqa_vld", 64'(valid_out), 64'd1);
        chk("seqa_ch",  64'(ch_out),    64'(seq_a[i-3]));
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 6) step(1, (i == 0) || (i == 2), 48'(i)); else step(0, 0, '0);
      if (i >= 3) begin
        chk("seqb_vld", 64'(valid_out), 64'd1);
        chk("seqb_ch",  64'(ch_out),    64'(seq_b[i-3]));
      end
    end

    // asynchronous reset with two beats in flight
    step(1, 1, 48'sd7);
    step(1, 0, 48'sd9);
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(valid_out), 64'd0);
    chk("arst_q",   64'(q_out),     64'd0);
    chk("arst_ch",  64'(ch_out),    64'd0);
    chk("arst_sat", 64'(sat_seen),  64'd0);
    model_reset();
    step(0, 0, '0);
    rst = 1'b0;
    repeat (4) step(0, 0, '0);
    beat_then_wait(0, 48'sd500);  expect_now("post_rst", 0, 8'd0, 0);

    // randomized traffic
    act_max = 8'($urandom_range(1, 255));
    step(0, 0, '0);
    for (int n = 0; n < 400; n++) begin
      rw = {$urandom, $urandom};
      rs = ($urandom_range(0, 3) == 0) ? rw[ACC_W-1:0] : 48'(int'($urandom_range(0, 4000)) - 2000);
      rw = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? rw[ACC_W-1:0] : 48'(int'($urandom_range(0, 400)) - 200);
      rm = ($urandom_range(0, 1) == 0) ? $urandom : 32'(32'h40000000 + int'($urandom_range(0, 2000)) - 1000);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0, rs,
           $urandom_range(0, 5) == 0, CH_W'($urandom_range(0, NUM_CH - 1)),
           rb, rm, SHIFT_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 2)));
    end
    repeat (5) step(0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/requant_stage.md
# requant_stage

Per-channel requantization stage sitting directly downstream of the depthwise/pointwise adder tree. It consumes one signed ACC_W-bit accumulator sum per valid beat, adds a per-channel bias, scales by a per-channel Q31 multiplier with rounding right shift, and clamps to an OUT_W-bit activation for the next layer's line buffer. It is fully pipelined, accepts one beat per cycle, has fixed latency and no backpressure.

## Interface
- ACC_W, 48, width of incoming accumulator sum (matches adder tree output)
- OUT_W, 8, width of quantized output activation
- NUM_CH, 32, channels per pixel; channel counter modulus
- MULT_W, 32, signed Q31 multiplier width
- SHIFT_W, 5, extra right-shift field width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write strobe for per-channel tables
- cfg_addr  in  $clog2(NUM_CH)  channel index written
- cfg_bias  in  ACC_W  signed bias
- cfg_mult  in  MULT_W  signed Q31 multiplier
- cfg_shift  in  SHIFT_W  additional right shift
- act_max  in  OUT_W  upper clamp (ReLU6 ceiling in quantized units), quasi-static
- frame_start  in  1  qualifies valid_in; marks the beat as channel 0
- valid_in  in  1  sum_in valid
- sum_in  in  ACC_W  signed accumulator from adder tree
- valid_out  out  1  q_out valid
- ch_out  out  $clog2(NUM_CH)  channel index of q_out
- q_out  out  OUT_W  quantized activation
- sat_seen  out  1  sticky: a clamp bound was hit since last frame_start

## Operation
- Channel counter ch_cnt: beat channel = 0 if frame_start&valid_in, else ch_cnt. After each valid beat ch_cnt = beat channel+1, wrapping NUM_CH-1 -> 0. frame_start without valid_in ignored.
- Tables: NUM_CH-entry register arrays for bias/mult/shift, written on cfg_we. Read in stage 1 with beat channel. Same-cycle write and read of the same entry: beat uses OLD value; new value applies from next beat.
- S1: a = sum_in + bias (ACC_W+1 bits, no saturation); capture mult, shift, channel.
- S2: p = a * mult (ACC_W+1+MULT_W bits, signed).
- S3: r = (p + 2^(30+shift)) >>> (31+shift), arithmetic (round half up).
- S4: clamp. Hit of either bound sets sat_seen.
- sat_seen cleared by frame_start&valid_in (that beat's own saturation still sets it, set wins).
- Non-valid beats propagate valid=0; q_out/ch_out hold last value.

## Timing
- Latency exactly 4 cycles valid_in -> valid_out; throughput 1 beat/cycle, back-to-back beats supported.
- Reset (async, any time): all pipeline valids 0, valid_out=0, q_out=0, ch_out=0, sat_seen=0, ch_cnt=0, tables bias=0, mult=0, shift=0. In-flight beats discarded; first post-reset beat is channel 0.
- cfg writes take effect for beats entering S1 on the cycle after cfg_we.

## Configuration
- REQUANT_RELU6_EN defined: clamp to [0, act_max]; q_out is unsigned.
- Undefined: linear (no-activation) mode for bottleneck projection layers; clamp to signed [-2^(OUT_W-1), 2^(OUT_W-1)-1]; act_max ignored; q_out is two's complement.

## Test plan
- ch0 bias=0, mult=0x40000000, shift=0; frame_start beat sum_in=20 -> 4 cycles later valid_out=1, ch_out=0, q_out=10, sat_seen=0.
- Rounding, same config: sum_in=21 -> 11; sum_in=-21 -> 0 with REQUANT_RELU6_EN (sat_seen=1), -10 without.
- bias=-100, mult=0x7FFFFFFF, shift=2, sum_in=300 -> 50; act_max=96, mult=0x40000000, shift=0, bias=0, sum_in=1000 -> 96 (RELU6) / 127 (linear), sat_seen=1 until next frame_start.
- NUM_CH=4, six back-to-back beats -> ch_out 0,1,2,3,0,1 on consecutive cycles; repeat with frame_start on third beat -> 0,1,0,1,2,3.
- cfg_we to ch1 mult in same cycle as a ch1 beat -> that beat uses old mult, next ch1 beat uses new.
- Assert rst with 2 beats in flight -> valid_out=0, q_out=0 immediately; no stale outputs afterwards; next beat reports ch_out=0 and mult=0 gives q_out=0.
